// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store size
// codes (funct3), word geometry and the transaction FSM state encoding.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 4;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for one 32-bit little-endian word.
//   we, size, addr_lo : captured request attributes (funct3 size, byte offset)
//   rword             : word currently held at the addressed index
//   wdata             : store data (low-order lanes meaningful)
//   be                : byte enables for a store
//   wdata_lane        : store data replicated onto the addressed lanes
//   rdata_ext         : selected and sign/zero-extended load data
//   bad               : illegal size or misaligned access
module dmem_align
    import dmem_pkg::*;
(
    input  logic              we,
    input  logic [2:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] rword,
    input  logic [WORD_W-1:0] wdata,
    output logic [LANES-1:0]  be,
    output logic [WORD_W-1:0] wdata_lane,
    output logic [WORD_W-1:0] rdata_ext,
    output logic              bad
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Lane selection for loads
    always_comb begin
        case (addr_lo)
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    // Size decode: enables, steering, extension and fault detection
    always_comb begin
        be         = '0;
        wdata_lane = '0;
        rdata_ext  = '0;
        bad        = 1'b0;
        case (size)
            SZ_B: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{rbyte[7]}}, rbyte};
            end
            SZ_BU: begin
                // unsigned sizes exist only for loads
                bad        = we;
                rdata_ext  = {24'd0, rbyte};
            end
            SZ_H: begin
                bad        = addr_lo[0];
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{rhalf[15]}}, rhalf};
            end
            SZ_HU: begin
                bad        = addr_lo[0] | we;
                rdata_ext  = {16'd0, rhalf};
            end
            SZ_W: begin
                bad        = (addr_lo != 2'd0);
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target for the CPU load/store path.
//   CLK, rst                      : clock, async active-high reset
//   req_valid/req_ready           : request handshake (ready only when idle)
//   req_we, req_size, req_addr,
//   req_wdata                     : store flag, funct3 size, byte address, data
//   rsp_valid/rsp_ready           : response handshake
//   rsp_rdata, rsp_err            : extended load data (0 for stores/faults), fault
// A request is captured on acceptance, the access happens LATENCY edges later,
// and the registered response is held until consumed.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned WORDS  = 1 << DEPTH_LOG2;
    localparam int unsigned IDX_LO = 2;
    localparam int unsigned IDX_HI = DEPTH_LOG2 + 1;

    dmem_state_t           state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic                  cap_we;
    logic [2:0]            cap_size;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic                  accept;
    logic                  access;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  rsp_err_d;

    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic [DEPTH_LOG2-1:0] widx;
    logic [DATA_WIDTH-1:0] rword;
    logic [DATA_WIDTH-1:0] wlane;
    logic [DATA_WIDTH-1:0] rext;
    logic [LANES-1:0]      be;
    logic                  align_bad;
    logic                  oor;
    logic                  err;
    logic                  do_write;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    assign widx  = cap_addr[IDX_HI:IDX_LO];
    assign rword = mem[widx];
    // Any address bit above the array's byte range is a fault, not an alias
    assign oor   = (cap_addr >> (DEPTH_LOG2 + 2)) != '0;
    assign err   = align_bad | oor;

    dmem_align u_align (
        .we         (cap_we),
        .size       (cap_size),
        .addr_lo    (cap_addr[1:0]),
        .rword      (rword),
        .wdata      (cap_wdata),
        .be         (be),
        .wdata_lane (wlane),
        .rdata_ext  (rext),
        .bad        (align_bad)
    );

    // Next-state, counter and response update
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        accept      = 1'b0;
        access      = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                end else begin
                    access      = 1'b1;
                    rsp_err_d   = err;
                    rsp_rdata_d = (err || cap_we) ? '0 : rext;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign do_write = access & cap_we & ~err;

    // FSM, counter, capture and response registers
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_size  <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            if (accept) begin
                cap_we    <= req_we;
                cap_size  <= req_size;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
        end
    end

    // Storage is deliberately not reset; lane-masked store
    always_ff @(posedge CLK) begin
        if (do_write) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (be[i]) mem[widx][i*8 +: 8] <= wlane[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance driven from a vector table
// plus reset/backpressure sequences, and a LATENCY=1 instance run back-to-back.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned LAT0  = 2;
    localparam int unsigned LAT1  = 1;
    localparam int          BOUND = 50;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    always #5 CLK = ~CLK;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata, rsp_rdata;

    logic        req_valid1, req_ready1, req_we1, rsp_valid1, rsp_ready1, rsp_err1;
    logic [2:0]  req_size1;
    logic [31:0] req_addr1, req_wdata1, rsp_rdata1;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(LAT0)) dut (
        .CLK(CLK), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(LAT1)) dut1 (
        .CLK(CLK), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_size(req_size1), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    rsp_t q0[$];
    rsp_t q1[$];
    vec_t tbl[$];
    vec_t b2b[$];
    rsp_t e0, e1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
        vec_t v;
        v.we = we; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    // Scoreboards: compare whenever a response is handed over
    always @(negedge CLK) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (q0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut_unexpected_rsp: got rdata 0x%08h with no expected entry", rsp_rdata);
            end else begin
                e0 = q0.pop_front();
                chk("dut_rsp_rdata", rsp_rdata, e0.rdata);
                chk("dut_rsp_err", 32'(rsp_err), 32'(e0.err));
            end
        end
    end

    always @(negedge CLK) begin
        if (!rst && rsp_valid1 && rsp_ready1) begin
            if (q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut1_unexpected_rsp: got rdata 0x%08h with no expected entry", rsp_rdata1);
            end else begin
                e1 = q1.pop_front();
                chk("dut1_rsp_rdata", rsp_rdata1, e1.rdata);
                chk("dut1_rsp_err", 32'(rsp_err1), 32'(e1.err));
            end
        end
    end

    task automatic push0(input logic [31:0] rd, input logic er);
        rsp_t e;
        e.rdata = rd; e.err = er;
        q0.push_back(e);
    endtask

    task automatic drive(input logic we, input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    endtask

    // After acceptance the request lines are junk that must be ignored
    task automatic scramble();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_size  = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic send(input bit push, input vec_t v);
        int n = 0;
        if (push) push0(v.rdata, v.err);
        drive(v.we, v.size, v.addr, v.wdata);
        while (!req_ready && n < BOUND) begin @(posedge CLK); #1; n++; end
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: req_ready still 0 after %0d cycles", n);
        end
        @(posedge CLK); #1;
        scramble();
    endtask

    task automatic wait_rsp(input int exp_lat, input string tag);
        int lat = 0;
        while (!rsp_valid && lat < BOUND) begin
            chk({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
            @(posedge CLK); #1; lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        chk({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_req_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic xact(input vec_t v, input string tag);
        send(1'b1, v);
        wait_rsp(LAT0, tag);
        consume(tag);
    endtask

    int acc [16];

    initial begin
        req_valid = 0; req_we = 0; req_size = 0; req_addr = 0; req_wdata = 0; rsp_ready = 1;
        req_valid1 = 0; req_we1 = 0; req_size1 = 0; req_addr1 = 0; req_wdata1 = 0; rsp_ready1 = 1;

        tbl.push_back(mk(1, SZ_W,  32'h20,   32'h8765_4321, 32'h0000_0000, 0));
        tbl.push_back(mk(0, SZ_W,  32'h20,   32'h0,         32'h8765_4321, 0));
        tbl.push_back(mk(0, SZ_W,  32'h50,   32'h0,         32'h1234_5678, 0));
        tbl.push_back(mk(1, SZ_W,  32'h30,   32'h1122_3344, 32'h0000_0000, 0));
        tbl.push_back(mk(1, SZ_B,  32'h31,   32'h1234_56AA, 32'h0000_0000, 0));
        tbl.push_back(mk(1, SZ_H,  32'h32,   32'hABCD_00F0, 32'h0000_0000, 0));
        tbl.push_back(mk(0, SZ_W,  32'h30,   32'h0,         32'h00F0_AA44, 0));
        tbl.push_back(mk(0, SZ_B,  32'h31,   32'h0,         32'hFFFF_FFAA, 0));
        tbl.push_back(mk(0, SZ_BU, 32'h31,   32'h0,         32'h0000_00AA, 0));
        tbl.push_back(mk(0, SZ_H,  32'h32,   32'h0,         32'h0000_00F0, 0));
        tbl.push_back(mk(0, SZ_H,  32'h30,   32'h0,         32'hFFFF_AA44, 0));
        tbl.push_back(mk(0, SZ_HU, 32'h30,   32'h0,         32'h0000_AA44, 0));
        tbl.push_back(mk(0, SZ_B,  32'h32,   32'h0,         32'hFFFF_FFF0, 0));
        tbl.push_back(mk(0, SZ_BU, 32'h33,   32'h0,         32'h0000_0000, 0));
        tbl.push_back(mk(1, SZ_W,  32'h40,   32'hCAFE_F00D, 32'h0000_0000, 0));
        tbl.push_back(mk(0, SZ_W,  32'h41,   32'h0,         32'h0000_0000, 1));
        tbl.push_back(mk(1, SZ_H,  32'h43,   32'h0000_FFFF, 32'h0000_0000, 1));
        tbl.push_back(mk(0, 3'b011, 32'h40,  32'h0,         32'h0000_0000, 1));
        tbl.push_back(mk(1, SZ_BU, 32'h40,   32'hFFFF_FFFF, 32'h0000_0000, 1));
        tbl.push_back(mk(1, SZ_W,  32'h1040, 32'h0BAD_0BAD, 32'h0000_0000, 1));
        tbl.push_back(mk(0, SZ_H,  32'h41,   32'h0,         32'h0000_0000, 1));
        tbl.push_back(mk(0, SZ_HU, 32'h43,   32'h0,         32'h0000_0000, 1));
        tbl.push_back(mk(0, 3'b110, 32'h40,  32'h0,         32'h0000_0000, 1));
        tbl.push_back(mk(1, 3'b111, 32'h40,  32'h1111_1111, 32'h0000_0000, 1));
        tbl.push_back(mk(0, SZ_W,  32'h40,   32'h0,         32'hCAFE_F00D, 0));
        tbl.push_back(mk(1, SZ_W,  32'h0,    32'h55AA_55AA, 32'h0000_0000, 0));
        tbl.push_back(mk(1, SZ_W,  32'h1000, 32'h0,         32'h0000_0000, 1));
        tbl.push_back(mk(0, SZ_W,  32'h0,    32'h0,         32'h55AA_55AA, 0));
        tbl.push_back(mk(0, SZ_W,  32'h1000, 32'h0,         32'h0000_0000, 1));
        tbl.push_back(mk(1, SZ_H,  32'h42,   32'h0000_1234, 32'h0000_0000, 0));
        tbl.push_back(mk(0, SZ_W,  32'h40,   32'h0,         32'h1234_F00D, 0));
        tbl.push_back(mk(0, SZ_HU, 32'h42,   32'h0,         32'h0000_1234, 0));
        tbl.push_back(mk(1, SZ_W,  32'hFFC,  32'h0BAD_F00D, 32'h0000_0000, 0));
        tbl.push_back(mk(0, SZ_W,  32'hFFC,  32'h0,         32'h0BAD_F00D, 0));
        tbl.push_back(mk(0, SZ_B,  32'hFFF,  32'h0,         32'h0000_000B, 0));
        tbl.push_back(mk(1, SZ_W,  32'h8000_0000, 32'h1, 32'h0000_0000, 1));

        b2b.push_back(mk(1, SZ_W,  32'h80, 32'h1357_9BDF, 32'h0000_0000, 0));
        b2b.push_back(mk(0, SZ_W,  32'h80, 32'h0,         32'h1357_9BDF, 0));
        b2b.push_back(mk(1, SZ_W,  32'h84, 32'hFEDC_BA98, 32'h0000_0000, 0));
        b2b.push_back(mk(0, SZ_W,  32'h84, 32'h0,         32'hFEDC_BA98, 0));
        b2b.push_back(mk(1, SZ_B,  32'h86, 32'h0000_0077, 32'h0000_0000, 0));
        b2b.push_back(mk(0, SZ_BU, 32'h86, 32'h0,         32'h0000_0077, 0));
        b2b.push_back(mk(0, SZ_W,  32'h84, 32'h0,         32'hFE77_BA98, 0));

        // Request held across reset release is taken on the first free edge
        push0(32'h0, 1'b0);
        drive(1'b1, SZ_W, 32'h50, 32'h1234_5678);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_dut1_req_ready", 32'(req_ready1), 32'd1);
        rst = 1'b0;
        @(posedge CLK); #1;
        chk("release_accept", 32'(req_ready), 32'd0);
        scramble();
        wait_rsp(LAT0, "release");
        consume("release");

        for (int i = 0; i < tbl.size(); i++) xact(tbl[i], $sformatf("v%0d", i));

        // Reset during WAIT drops the pending store
        xact(mk(1, SZ_W, 32'h10, 32'h0, 32'h0, 0), "rst_pre");
        send(1'b0, mk(1, SZ_W, 32'h10, 32'hDEAD_BEEF, 32'h0, 0));
        @(posedge CLK); #1;
        chk("rst_mid_still_waiting", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        #2;
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mid_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        xact(mk(0, SZ_W, 32'h10, 32'h0, 32'h0000_0000, 0), "rst_post_load");

        // Backpressure: held response, queued request waits for the idle cycle
        xact(mk(1, SZ_W, 32'h60, 32'hA5A5_0F0F, 32'h0, 0), "bp_store");
        rsp_ready = 1'b0;
        send(1'b1, mk(0, SZ_W, 32'h60, 32'h0, 32'hA5A5_0F0F, 0));
        wait_rsp(LAT0, "bp_load");
        push0(32'h8765_4321, 1'b0);
        drive(1'b0, SZ_W, 32'h20, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
            chk("bp_rdata_stable", rsp_rdata, 32'hA5A5_0F0F);
            chk("bp_err_stable", 32'(rsp_err), 32'd0);
            chk("bp_req_ready_low", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        chk("bp_idle_req_ready", 32'(req_ready), 32'd1);
        chk("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge CLK); #1;
        chk("bp_next_accepted", 32'(req_ready), 32'd0);
        scramble();
        wait_rsp(LAT0, "bp_next");
        consume("bp_next");

        // LATENCY=1 instance, valid and ready held high: idle + wait + resp per transaction
        req_valid1 = 1'b1;
        rsp_ready1 = 1'b1;
        for (int i = 0; i < b2b.size(); i++) begin
            rsp_t e;
            int   n;
            e.rdata = b2b[i].rdata; e.err = b2b[i].err;
            q1.push_back(e);
            req_we1 = b2b[i].we; req_size1 = b2b[i].size;
            req_addr1 = b2b[i].addr; req_wdata1 = b2b[i].wdata;
            n = 0;
            while (!req_ready1 && n < BOUND) begin @(posedge CLK); #1; n++; end
            @(posedge CLK); #1;
            acc[i] = cyc;
            if (i > 0) chk("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'(LAT1 + 2));
        end
        req_valid1 = 1'b0;
        repeat (4) @(posedge CLK);
        #1;

        chk("dut_queue_drained", 32'(q0.size()), 32'd0);
        chk("dut1_queue_drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit with %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
